// File: rtl/keypad_scan_encoder_if.sv
// Keypad encoder interface bundle: row inputs, column drive and encoded key outputs.
//
// Handshake: key_valid is a one-cycle strobe with no ready (the consumer
// cannot stall the keypad). key_code is valid while key_valid is high and
// stays stable until the next accepted press. key_valid never stays high for
// two consecutive cycles.
interface keypad_scan_encoder_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_err;

  // Keypad and consumer side: drives the rows and observes the encoder outputs.
  modport master (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_err
  );

  // Encoder side.
  modport slave (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down,
    output multi_err
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, samples the
// rows through a 2-flop synchronizer, evaluates the 16-key snapshot once per
// frame and debounces single presses into a key code with a valid strobe.
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_scan_encoder_if.slave kp,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N    = 4'(DEBOUNCE);

  logic [3:0]  sync1_q, row_s;
  logic [7:0]  div_q;
  logic [1:0]  col_q;
  logic [3:0]  col_n_q;
  logic [11:0] snap_q;      // columns 0..2; column 3 is taken live at frame end
  logic        capture, frame_end;
  logic [15:0] frame_snap;  // bit index = col*4 + row, 1 = key closed
  logic [4:0]  hit_cnt;
  logic [3:0]  hit_idx;
  logic        is_none, is_single, is_multi;
  logic [3:0]  frame_key;

  state_t      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  dcnt_q, dcnt_d, dcnt_inc;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        down_q, down_d;
  logic        multi_q, multi_d;

  assign capture    = (div_q == DIV_LAST);
  assign frame_end  = capture && (col_q == 2'd3);
  assign frame_snap = {~row_s, snap_q};
  assign dcnt_inc   = dcnt_q + 4'd1;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      row_s   <= 4'hF;
    end else begin
      sync1_q <= kp.row_n;
      row_s   <= sync1_q;
    end
  end

  // Dwell counter, column rotation and per-column row capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 8'd0;
      col_q   <= 2'd0;
      col_n_q <= 4'b1110;
      snap_q  <= 12'd0;
    end else if (capture) begin
      div_q   <= 8'd0;
      col_q   <= col_q + 2'd1;
      col_n_q <= {col_n_q[2:0], col_n_q[3]};
      case (col_q)
        2'd0:    snap_q[3:0]  <= ~row_s;
        2'd1:    snap_q[7:4]  <= ~row_s;
        2'd2:    snap_q[11:8] <= ~row_s;
        default: ;
      endcase
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  // Classify the completed frame: count closed keys and locate the last one.
  always_comb begin
    hit_cnt = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_snap[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    is_none   = (hit_cnt == 5'd0);
    is_single = (hit_cnt == 5'd1);
    is_multi  = (hit_cnt >= 5'd2);
    // Snapshot index is col*4+row; the key code is row*4+col.
    frame_key = {hit_idx[1:0], hit_idx[3:2]};
  end

  // Debounce state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      dcnt_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
      multi_q <= multi_d;
    end
  end

  // Next-state and output logic, evaluated only at frame end.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    multi_d = multi_q;
    if (frame_end) begin
      multi_d = is_multi;
      case (state_q)
        IDLE: begin
          if (is_single) begin
            if (DEB_N == 4'd1) begin
              state_d = HELD;
              code_d  = frame_key;
              valid_d = 1'b1;
              down_d  = 1'b1;
              dcnt_d  = DEB_N;
            end else begin
              state_d = DEB_PRESS;
              cand_d  = frame_key;
              dcnt_d  = 4'd1;
            end
          end
        end
        DEB_PRESS: begin
          if (is_single && frame_key == cand_q) begin
            if (dcnt_inc >= DEB_N) begin
              state_d = HELD;
              code_d  = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
              dcnt_d  = DEB_N;
            end else begin
              dcnt_d = dcnt_inc;
            end
          end else if (is_single) begin
            cand_d = frame_key;
            dcnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            dcnt_d  = 4'd0;
          end
        end
        HELD: begin
          if (is_none) begin
            if (DEB_N == 4'd1) begin
              state_d = IDLE;
              down_d  = 1'b0;
              dcnt_d  = 4'd0;
            end else begin
              state_d = DEB_REL;
              dcnt_d  = 4'd1;
            end
          end
        end
        DEB_REL: begin
          if (is_none) begin
            if (dcnt_inc >= DEB_N) begin
              state_d = IDLE;
              down_d  = 1'b0;
              dcnt_d  = 4'd0;
            end else begin
              dcnt_d = dcnt_inc;
            end
          end else begin
            state_d = HELD;
            dcnt_d  = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_down  = down_q;
  assign kp.multi_err = multi_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dbg_state;
  logic [15:0] pressed = 16'd0;   // key k = row*4 + col closed
  logic [3:0]  row_v;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          last_valid_cyc = -1;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_q[$];

  keypad_scan_encoder_if kp ();

  keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .kp        (kp),
    .dbg_state (dbg_state)
  );

  // Clock and reset-relative cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Keypad matrix model: a row reads low when a closed key sits on a driven column.
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(pressed[r*4 +: 4] & ~kp.col_n)) row_v[r] = 1'b0;
  end
  assign kp.row_n = row_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected key code.
  always @(negedge clk) begin
    if (!rst && kp.key_valid) begin
      check("valid_consec", prev_valid, 1'b0);
      check("valid_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("key_code", kp.key_code, exp_q.pop_front());
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    prev_valid = kp.key_valid;
  end

  task automatic do_reset(input logic [15:0] keys);
    rst     = 1'b1;
    pressed = keys;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    valid_cnt      = 0;
    last_valid_cyc = -1;
  endtask

  // Return just after the falling edge that follows rising edge 'target'.
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"}, kp.col_n, 4'b1110);
    check({tag, "_code"},  kp.key_code, 4'd0);
    check({tag, "_valid"}, kp.key_valid, 1'b0);
    check({tag, "_down"},  kp.key_down, 1'b0);
    check({tag, "_multi"}, kp.multi_err, 1'b0);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    logic [3:0] exp_col;
    int         col_i;

    // Reset values and column rotation with no keys.
    do_reset(16'h0000);
    @(negedge clk); #1;
    check_reset_outputs("rst");
    for (int n = 1; n <= 16; n++) begin
      wait_cyc(n);
      col_i   = (n / 4) % 4;
      exp_col = ~(4'b0001 << col_i);
      check("col_scan", kp.col_n, exp_col);
    end
    check("idle_down", kp.key_down, 1'b0);
    check("idle_valid_cnt", valid_cnt, 0);

    // Single press of key 9 (row 2, col 1) held from reset, then release.
    do_reset(16'h0200);
    exp_q.push_back(4'd9);
    wait_cyc(47);
    check("single_early", valid_cnt, 0);
    wait_cyc(48);
    check("single_latency", last_valid_cyc, 48);
    check("single_down", kp.key_down, 1'b1);
    check("single_code", kp.key_code, 4'd9);
    pressed = 16'h0000;
    wait_cyc(95);
    check("rel_down_hold", kp.key_down, 1'b1);
    wait_cyc(96);
    check("rel_down_clear", kp.key_down, 1'b0);
    check("rel_code_kept", kp.key_code, 4'd9);
    check("single_cnt", valid_cnt, 1);

    // Bounce: key 5 for two frames, open one, then three frames.
    do_reset(16'h0020);
    exp_q.push_back(4'd5);
    wait_cyc(32);
    pressed = 16'h0000;
    wait_cyc(48);
    pressed = 16'h0020;
    wait_cyc(95);
    check("bounce_early", valid_cnt, 0);
    wait_cyc(96);
    check("bounce_cnt", valid_cnt, 1);
    check("bounce_latency", last_valid_cyc, 96);
    check("bounce_down", kp.key_down, 1'b1);

    // Two keys (0 and 15): multi error, then key 0 alone is accepted.
    do_reset(16'h8001);
    wait_cyc(15);
    check("multi_pre", kp.multi_err, 1'b0);
    wait_cyc(16);
    check("multi_set", kp.multi_err, 1'b1);
    wait_cyc(32);
    check("multi_no_valid", valid_cnt, 0);
    pressed = 16'h0001;
    exp_q.push_back(4'd0);
    wait_cyc(47);
    check("multi_hold", kp.multi_err, 1'b1);
    wait_cyc(48);
    check("multi_clear", kp.multi_err, 1'b0);
    wait_cyc(79);
    check("multi_early", valid_cnt, 0);
    wait_cyc(80);
    check("multi_cnt", valid_cnt, 1);
    check("multi_latency", last_valid_cyc, 80);
    check("multi_down", kp.key_down, 1'b1);

    // Rollover: key 3 accepted, key 7 added, key 3 dropped, then all released.
    do_reset(16'h0008);
    exp_q.push_back(4'd3);
    wait_cyc(48);
    check("roll_latency", last_valid_cyc, 48);
    pressed = 16'h0088;
    wait_cyc(64);
    check("roll_multi", kp.multi_err, 1'b1);
    pressed = 16'h0080;
    wait_cyc(96);
    check("roll_code", kp.key_code, 4'd3);
    check("roll_down", kp.key_down, 1'b1);
    check("roll_multi_clr", kp.multi_err, 1'b0);
    pressed = 16'h0000;
    wait_cyc(143);
    check("roll_down_hold", kp.key_down, 1'b1);
    check("roll_cnt", valid_cnt, 1);
    wait_cyc(144);
    check("roll_down_clear", kp.key_down, 1'b0);

    // Reset while held; the key is re-accepted after three frames.
    do_reset(16'h0200);
    exp_q.push_back(4'd9);
    wait_cyc(48);
    check("mid_down", kp.key_down, 1'b1);
    wait_cyc(60);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    valid_cnt      = 0;
    last_valid_cyc = -1;
    exp_q.push_back(4'd9);
    wait_cyc(48);
    check("reacc_latency", last_valid_cyc, 48);
    check("reacc_down", kp.key_down, 1'b1);
    check("reacc_code", kp.key_code, 4'd9);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
